// File: rtl/seg_to_hex_encoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_to_hex_encoder
// Purpose  : Recovers a 4-digit hexadecimal value by watching the drive lines
//            of a multiplexed, active-low 7-segment display.
//            Each sampled {AN, A..G} vector must stay unchanged for
//            STABLE_CYCLES consecutive samples before it is accepted as a
//            digit. Once all four digit slots are filled, the frame is
//            presented on VALUE/VALID with a valid/ready handshake.
//
// Parameters:
//   STABLE_CYCLES  identical consecutive samples required to capture (2..255)
//
// Ports:
//   CLK            in   1   single clock, rising edge
//   RST            in   1   synchronous, active-high reset
//   A..G           in   1   segment lines, active-low (0 = lit)
//   AN             in   4   digit enables, active-low, AN[0] = least significant
//   READY          in   1   consumer takes VALUE when VALID && READY
//   VALUE          out  16  recovered value, digit i in VALUE[4i+3:4i]
//   VALID          out  1   VALUE holds a complete, unconsumed frame
//   ERR            out  1   one-cycle pulse on capture of an unknown pattern
//   OVERRUN        out  1   sticky: a complete frame was dropped
//
// Build option:
//   SEG_ENCODER_ERR_EN  defined   -> unknown patterns fill their slot with 0,
//                                    count toward the frame and pulse ERR
//                       undefined -> unknown patterns are ignored, ERR = 0
//
// Revision : 1.0  initial release
// ============================================================================
module seg_to_hex_encoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        A,
  input  logic        B,
  input  logic        C,
  input  logic        D,
  input  logic        E,
  input  logic        F,
  input  logic        G,
  input  logic [3:0]  AN,
  input  logic        READY,
  output logic [15:0] VALUE,
  output logic        VALID,
  output logic        ERR,
  output logic        OVERRUN
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // The counter holds (identical consecutive samples - 1) for the older of
  // the two compared samples, so the newest sample completes a run of
  // STABLE_CYCLES when the counter reads STABLE_CYCLES-2 and the pair matches.
  localparam logic [7:0]  c_cnt_fire   = 8'(STABLE_CYCLES - 2);
  localparam logic [7:0]  c_cnt_max    = 8'hFF;
  localparam logic [10:0] c_sample_idle = 11'h7FF;  // AN=1111, all segments dark

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Segment pattern decoder: returns {recognised, code}
  // --------------------------------------------------------------------------
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'b0_0000;
    case (seg)
      7'b0000001: res = {1'b1, 4'h0};
      7'b1001111: res = {1'b1, 4'h1};
      7'b0010010: res = {1'b1, 4'h2};
      7'b0000110: res = {1'b1, 4'h3};
      7'b1001100: res = {1'b1, 4'h4};
      7'b0100100: res = {1'b1, 4'h5};
      7'b0100000: res = {1'b1, 4'h6};
      7'b0001111: res = {1'b1, 4'h7};
      7'b0000000: res = {1'b1, 4'h8};
      7'b0000100: res = {1'b1, 4'h9};
      7'b0001000: res = {1'b1, 4'hA};
      7'b1100000: res = {1'b1, 4'hB};
      7'b0110001: res = {1'b1, 4'hC};
      7'b1000010: res = {1'b1, 4'hD};
      7'b0110000: res = {1'b1, 4'hE};
      7'b0111000: res = {1'b1, 4'hF};
      default:    res = 5'b0_0000;
    endcase
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [10:0] sample_q,  sample_d;   // newest {AN, A..G}
  logic [10:0] prev_q,    prev_d;     // sample one cycle older
  logic [7:0]  cnt_q,     cnt_d;      // stability counter
  logic [15:0] shadow_q,  shadow_d;   // per-digit collection slots
  logic [3:0]  mask_q,    mask_d;     // slots written since last frame
  logic [15:0] value_q,   value_d;
  logic        valid_q,   valid_d;
  logic        err_q,     err_d;
  logic        overrun_q, overrun_d;
  state_t      state_q,   state_d;

  // --------------------------------------------------------------------------
  // Sampling and stability detection
  // --------------------------------------------------------------------------
  logic [3:0] an_low;       // 1 = digit selected
  logic [6:0] samp_seg;
  logic       same;
  logic       one_hot;
  logic       fire;         // this sample completes a stable run
  logic [4:0] dec;
  logic       cap_en;
  logic [3:0] cap_code;
  logic [3:0] cap_mask;

  always_comb begin
    sample_d = {AN, A, B, C, D, E, F, G};
    prev_d   = sample_q;

    an_low   = ~sample_q[10:7];
    samp_seg = sample_q[6:0];
    same     = (sample_q == prev_q);

    // Exactly one enable low: non-zero and a power of two.
    one_hot  = (an_low != 4'b0000) && ((an_low & (an_low - 4'd1)) == 4'b0000);

    if (!same) begin
      cnt_d = 8'd0;
    end else if (cnt_q == c_cnt_max) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    // The counter only passes through c_cnt_fire once per run, so holding a
    // pattern longer never recaptures it.
    fire = same && (cnt_q == c_cnt_fire) && one_hot;
    dec  = decode_seg(samp_seg);

`ifdef SEG_ENCODER_ERR_EN
    cap_en   = fire;
    cap_code = dec[3:0];            // decoder already yields 0 when unknown
    err_d    = fire && !dec[4];
`else
    cap_en   = fire && dec[4];
    cap_code = dec[3:0];
    err_d    = 1'b0;
`endif

    cap_mask = cap_en ? an_low : 4'b0000;
  end

  // --------------------------------------------------------------------------
  // Slot collection and frame hand-off
  // --------------------------------------------------------------------------
  logic frame_done;
  logic handshake;

  always_comb begin
    frame_done = (mask_q == 4'hF);
    handshake  = valid_q && READY;

    shadow_d = shadow_q;
    for (int i = 0; i < 4; i++) begin
      if (cap_mask[i]) begin
        shadow_d[4*i +: 4] = cap_code;
      end
    end

    // A completed mask is consumed on this edge whether the frame is loaded
    // or dropped; a capture landing on the same edge starts the next frame.
    mask_d = (frame_done ? 4'b0000 : mask_q) | cap_mask;

    state_d   = state_q;
    value_d   = value_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    case (state_q)
      ST_COLLECT: begin
        if (frame_done) begin
          value_d = shadow_q;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (frame_done) begin
          if (handshake) begin
            // Old frame leaves as the new one arrives: stay presenting.
            value_d = shadow_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (handshake) begin
          valid_d = 1'b0;
          state_d = ST_COLLECT;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_COLLECT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      sample_q  <= c_sample_idle;
      prev_q    <= c_sample_idle;
      cnt_q     <= 8'd0;
      shadow_q  <= 16'h0000;
      mask_q    <= 4'b0000;
      value_q   <= 16'h0000;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
      state_q   <= ST_COLLECT;
    end else begin
      sample_q  <= sample_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      mask_q    <= mask_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
    end
  end

  assign VALUE   = value_q;
  assign VALID   = valid_q;
  assign ERR     = err_q;
  assign OVERRUN = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_to_hex_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_to_hex_encoder
// Purpose  : Scoreboard bench for seg_to_hex_encoder. Directed digit sequences
//            push their expected frames into a queue; a monitor pops and
//            compares each frame as the DUT presents it.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_to_hex_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        a, b, c, d, e, f, g;
  logic [3:0]  an;
  logic        ready;
  logic [15:0] value;
  logic        valid;
  logic        err;
  logic        overrun;

  always #5 clk = ~clk;

  seg_to_hex_encoder #(.STABLE_CYCLES(4)) dut (
    .CLK     (clk),
    .RST     (rst),
    .A       (a),
    .B       (b),
    .C       (c),
    .D       (d),
    .E       (e),
    .F       (f),
    .G       (g),
    .AN      (an),
    .READY   (ready),
    .VALUE   (value),
    .VALID   (valid),
    .ERR     (err),
    .OVERRUN (overrun)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          err_seen = 0;
  logic [15:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_hs    = 1'b0;
  logic [15:0] prev_value = 16'h0000;

  // Monitor: a new frame is presented when VALID rises, or when VALID stays
  // high across an edge that performed a handshake. Otherwise a held frame
  // must keep its value.
  always @(negedge clk) begin
    logic [15:0] exp_v;
    if (mon_en) begin
      if (err === 1'b1) err_seen++;
      if (valid === 1'b1 && (!prev_valid || prev_hs)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_unexpected: VALUE=%h presented, none expected", value);
        end else begin
          exp_v = exp_q.pop_front();
          if (value !== exp_v) begin
            n_fail++;
            $display("FAIL frame_value: VALUE=%h expected %h", value, exp_v);
          end
        end
      end else if (valid === 1'b1 && prev_valid && !prev_hs) begin
        n_cmp++;
        if (value !== prev_value) begin
          n_fail++;
          $display("FAIL frame_hold: VALUE=%h expected %h (held)", value, prev_value);
        end
      end
    end
    prev_valid = (valid === 1'b1);
    prev_hs    = (valid === 1'b1) && (ready === 1'b1);
    prev_value = value;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic [3:0] an_v, input logic [6:0] seg, input int cycles);
    an = an_v;
    {a, b, c, d, e, f, g} = seg;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic at_negedge();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    an    = 4'b1111;
    {a, b, c, d, e, f, g} = 7'b1111111;
    ready = 1'b1;
    idle(3);
    rst = 1'b0;
    at_negedge();

    check("reset_value",   value,          16'h0000);
    check("reset_valid",   {15'd0, valid},   16'h0000);
    check("reset_err",     {15'd0, err},     16'h0000);
    check("reset_overrun", {15'd0, overrun}, 16'h0000);
    mon_en = 1'b1;

    // Basic frame 5432h
    exp_q.push_back(16'h5432);
    drive(4'b1110, 7'b0010010, 6);
    drive(4'b1101, 7'b0000110, 6);
    drive(4'b1011, 7'b1001100, 6);
    drive(4'b0111, 7'b0100100, 6);
    idle(4);
    check("basic_acked", {15'd0, valid}, 16'h0000);

    // Overrun: 0000h left pending, 1111h dropped
    ready = 1'b0;
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 4; i++) drive(~(4'b0001 << i), 7'b0000001, 6);
    idle(3);
    check("ovr_first_valid", {15'd0, valid}, 16'h0001);
    for (int i = 0; i < 4; i++) drive(~(4'b0001 << i), 7'b1001111, 6);
    idle(3);
    check("ovr_flag",        {15'd0, overrun}, 16'h0001);
    check("ovr_value_kept",  value,            16'h0000);
    check("ovr_valid_kept",  {15'd0, valid},   16'h0001);
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    at_negedge();
    check("ovr_ack_clears",  {15'd0, valid},   16'h0000);
    check("ovr_sticky",      {15'd0, overrun}, 16'h0001);

    // Pattern toggling every 2 cycles on digit 0 never captures
    ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(4'b1110, 7'b0000000, 2);
      drive(4'b1110, 7'b0110001, 2);
    end
    check("toggle_no_valid", {15'd0, valid}, 16'h0000);
    drive(4'b1101, 7'b0000100, 6);
    drive(4'b1011, 7'b0001000, 6);
    drive(4'b0111, 7'b0001111, 6);
    idle(3);
    check("toggle_slot0_empty", {15'd0, valid}, 16'h0000);
    exp_q.push_back(16'h7A96);
    drive(4'b1110, 7'b0100000, 6);
    idle(4);

    // Unrecognised pattern on digit 0
`ifdef SEG_ENCODER_ERR_EN
    exp_q.push_back(16'hEDB0);
`endif
    drive(4'b1110, 7'b1111110, 6);
    drive(4'b1101, 7'b1100000, 6);
    drive(4'b1011, 7'b1000010, 6);
    drive(4'b0111, 7'b0110000, 6);
    idle(4);
`ifndef SEG_ENCODER_ERR_EN
    check("err_mask_bit0_clear", {15'd0, valid}, 16'h0000);
    exp_q.push_back(16'hEDBF);
    drive(4'b1110, 7'b0111000, 6);
    idle(4);
`endif

    // Reset mid-frame discards partial captures
    drive(4'b1110, 7'b0001111, 6);
    drive(4'b1101, 7'b0001111, 6);
    drive(4'b1111, 7'b1111111, 1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    at_negedge();
    check("rst2_value",   value,            16'h0000);
    check("rst2_valid",   {15'd0, valid},   16'h0000);
    check("rst2_overrun", {15'd0, overrun}, 16'h0000);
    drive(4'b1011, 7'b0110000, 6);
    drive(4'b0111, 7'b0111000, 6);
    idle(3);
    check("rst2_no_residue", {15'd0, valid}, 16'h0000);
    exp_q.push_back(16'hFEDC);
    drive(4'b1110, 7'b0110001, 6);
    drive(4'b1101, 7'b1000010, 6);
    idle(4);

    // Two enables low never capture
    drive(4'b1100, 7'b1001111, 10);
    idle(2);
    check("multi_an_no_valid", {15'd0, valid}, 16'h0000);
    drive(4'b1011, 7'b0000001, 6);
    drive(4'b0111, 7'b0000001, 6);
    idle(3);
    check("multi_an_no_slots", {15'd0, valid}, 16'h0000);

    idle(5);
    check("frames_pending", 16'(exp_q.size()), 16'h0000);
`ifdef SEG_ENCODER_ERR_EN
    check("err_pulses", 16'(err_seen), 16'h0001);
`else
    check("err_pulses", 16'(err_seen), 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
